// File: rtl/uart_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_pkg
//   Shared UART types and helpers for the transmit serializer and receiver.
//   - uart_baud_rate_t : supported line rates; each enumerator's value is the
//                        rate in bit/s.
//   - uart_tx_state_t  : transmit FSM states.
//   - uart_cpb()       : integer clocks-per-bit, rounded to nearest.
//   - is_pow2()        : power-of-two test for elaboration-time checks.
// -----------------------------------------------------------------------------
package uart_tx_serializer_pkg;

    typedef enum logic [31:0] {
        BR_9600   = 32'd9600,
        BR_19200  = 32'd19200,
        BR_38400  = 32'd38400,
        BR_57600  = 32'd57600,
        BR_115200 = 32'd115200
    } uart_baud_rate_t;

    typedef enum logic [1:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_STOP
    } uart_tx_state_t;

    // Adding half the baud rate first turns the truncating divide into round-to-nearest.
    function automatic int unsigned uart_cpb(int unsigned clk_hz, uart_baud_rate_t br);
        int unsigned baud;
        baud = br;
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic bit is_pow2(int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. o_rdata always shows the head
//   entry while o_empty is low. Pushes are ignored when full, pops when empty.
//   Ports:
//     i_clk    : clock
//     i_rst_n  : synchronous active-low reset (clears pointers and count)
//     i_push   : write i_wdata this cycle
//     i_wdata  : write data
//     i_pop    : discard the head entry this cycle
//     o_rdata  : head entry
//     o_full   : DEPTH entries stored
//     o_empty  : no entries stored
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmit path: bytes accepted over a valid/ready port are buffered
//   in a small FIFO and sent as 8N1 frames, LSB first, at a fixed baud rate.
//   Ports:
//     clk         : core clock
//     rst_n       : synchronous active-low reset
//     send_valid  : byte offered by the core
//     send_data   : byte to transmit (sampled only on the handshake)
//     send_ready  : byte accepted when send_valid && send_ready (= !fifo_full)
//     tx_ready    : UART_CTRL.tx_ready, identical to send_ready
//     busy        : frame in progress or bytes still buffered
//     serial_out  : TX line, idles high
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int unsigned     CLOCK_FREQ = 100_000_000,
    parameter uart_baud_rate_t BAUD_RATE  = BR_115200,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    output logic       send_ready,
    output logic       tx_ready,
    output logic       busy,
    output logic       serial_out
);

    localparam int unsigned CPB = uart_cpb(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned BW  = (CPB > 2) ? $clog2(CPB) : 1;

    generate
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_tx_serializer: clocks per bit must be at least 2");
        end
        if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 2)) begin : g_bad_depth
            $error("uart_tx_serializer: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    uart_tx_state_t r_state;
    uart_tx_state_t w_state_next;
    logic [BW-1:0]  r_baud;
    logic [BW-1:0]  w_baud_next;
    logic [2:0]     r_bit;
    logic [2:0]     w_bit_next;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_next;
    logic           r_serial;
    logic           w_serial_next;

    logic           w_tick;
    logic           w_pop;
    logic           w_ready;
    logic           w_push;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [7:0]     w_fifo_rdata;

    // Gating with rst_n keeps ready low for the whole reset, not only after
    // the first reset edge has cleared the FIFO count.
    assign w_ready    = rst_n && !w_fifo_full;
    assign w_push     = send_valid && w_ready;
    assign send_ready = w_ready;
    assign tx_ready   = w_ready;
    assign serial_out = r_serial;
    assign w_tick     = (r_baud == BW'(CPB - 1));

    sync_fifo #(
        .DW    (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_wdata (send_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= UTX_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_serial <= w_serial_next;
        end
    end

    // Next-state logic. The line level is registered from the next state, so
    // serial_out changes on the same edge as the state it belongs to.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = w_tick ? '0 : r_baud + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;

        case (r_state)
            UTX_IDLE: begin
                w_baud_next = '0;
                if (w_pop) begin
                    w_shift_next = w_fifo_rdata;
                    w_bit_next   = '0;
                    w_state_next = UTX_START;
                end
            end
            UTX_START: begin
                if (w_tick) begin
                    w_state_next = UTX_DATA;
                end
            end
            UTX_DATA: begin
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_next = UTX_STOP;
                    end
                end
            end
            UTX_STOP: begin
                if (w_tick) begin
                    if (w_pop) begin
                        w_shift_next = w_fifo_rdata;
                        w_bit_next   = '0;
                        w_state_next = UTX_START;
                    end else begin
                        w_state_next = UTX_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = UTX_IDLE;
            end
        endcase

        case (w_state_next)
            UTX_START: w_serial_next = 1'b0;
            UTX_DATA:  w_serial_next = w_shift_next[0];
            default:   w_serial_next = 1'b1;
        endcase
    end

    // Outputs of the current state.
    always_comb begin
        w_pop = 1'b0;
        if (!w_fifo_empty) begin
            if (r_state == UTX_IDLE) begin
                w_pop = 1'b1;
            end else if ((r_state == UTX_STOP) && w_tick) begin
                w_pop = 1'b1;
            end
        end
        busy = (r_state != UTX_IDLE) || !w_fifo_empty;
    end

endmodule
